// File: rtl/jogo_sequencia_pkg.sv
// Shared types and the fixed sequence ROM formula for the parametrised memory game.
// State codes are the values shown on the state display.
package jogo_sequencia_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL     = 4'h0,
        ST_PREPARACAO  = 4'h1,
        ST_ESPERA      = 4'h2,
        ST_REGISTRA    = 4'h3,
        ST_COMPARA     = 4'h4,
        ST_PROXIMO     = 4'h5,
        ST_FIM_ACERTO  = 4'hA,
        ST_FIM_ERRO    = 4'hE,
        ST_FIM_TIMEOUT = 4'hF
    } estado_t;

    typedef struct packed {
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    localparam saidas_t SAI_NADA    = '{pronto: 1'b0, acertou: 1'b0, errou: 1'b0, timeout: 1'b0};
    localparam saidas_t SAI_ACERTO  = '{pronto: 1'b1, acertou: 1'b1, errou: 1'b0, timeout: 1'b0};
    localparam saidas_t SAI_ERRO    = '{pronto: 1'b1, acertou: 1'b0, errou: 1'b1, timeout: 1'b0};
    localparam saidas_t SAI_TIMEOUT = '{pronto: 1'b1, acertou: 1'b0, errou: 1'b1, timeout: 1'b1};

    // ROM[a] = (3*a + 1) mod 2^data_w
    function automatic logic [31:0] rom_valor(input logic [31:0] addr, input int unsigned data_w);
        logic [31:0] v;
        logic [31:0] mask;
        v    = 32'd3 * addr + 32'd1;
        mask = (data_w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
        return v & mask;
    endfunction

endpackage

// File: rtl/jogo_sequencia_param_if.sv
// Player-side bus of the memory game: control inputs, verdict flags and debug buses.
interface jogo_sequencia_param_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic              jogada;
    logic [DATA_W-1:0] chaves;
    logic              pronto;
    logic              acertou;
    logic              errou;
    logic              timeout;
    logic              db_igual;
    logic [ADDR_W-1:0] db_contagem;
    logic [DATA_W-1:0] db_memoria;
    logic [DATA_W-1:0] db_jogada;
    logic [3:0]        db_estado;

    modport master (
        output iniciar, jogada, chaves,
        input  pronto, acertou, errou, timeout,
        input  db_igual, db_contagem, db_memoria, db_jogada, db_estado
    );

    modport slave (
        input  iniciar, jogada, chaves,
        output pronto, acertou, errou, timeout,
        output db_igual, db_contagem, db_memoria, db_jogada, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_param_rom.sv
// Combinational sequence ROM; contents come from the package formula, zero latency.
module sequencia_rom
    import jogo_sequencia_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_dado
);
    assign o_dado = DATA_W'(rom_valor(32'(i_addr), DATA_W));
endmodule

// File: rtl/jogo_sequencia_param.sv
// Parametrised memory game: player enters DEPTH values, each checked against the ROM.
// Optional idle timeout in ESPERA is enabled by defining JOGO_SEQUENCIA_TIMEOUT_EN.
//
// state          | meaning
// INICIAL    (0) | idle after reset, waits for iniciar
// PREPARACAO (1) | clears position, input register and timer
// ESPERA     (2) | waits for a rising edge of jogada
// REGISTRA   (3) | captures chaves into the input register
// COMPARA    (4) | checks register against ROM[pos]
// PROXIMO    (5) | advances the position
// FIM_ACERTO (A) | whole sequence matched
// FIM_ERRO   (E) | mismatch
// FIM_TIMEOUT(F) | no entry within TIMEOUT_CYCLES
module jogo_sequencia_param
    import jogo_sequencia_pkg::*;
#(
    parameter int DATA_W         = 4,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input logic                  clock,
    input logic                  reset,
    jogo_sequencia_param_if.slave bus
);
    localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(DEPTH - 1);

    estado_t           r_estado;
    saidas_t           r_saidas;
    logic              r_jogada_q;
    logic [ADDR_W-1:0] r_contagem;
    logic [DATA_W-1:0] r_registro;

    logic              w_jogada_ed;
    logic              w_igual;
    logic              w_expirou;
    logic [DATA_W-1:0] w_memoria;

    sequencia_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .i_addr (r_contagem),
        .o_dado (w_memoria)
    );

    assign w_jogada_ed = bus.jogada & ~r_jogada_q;
    assign w_igual     = (r_registro == w_memoria);

`ifdef JOGO_SEQUENCIA_TIMEOUT_EN
    localparam int                TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_FIM = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_timer;

    assign w_expirou = (r_timer == TMR_FIM);

    // Counts idle cycles in ESPERA; any other state (or leaving ESPERA) clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_estado == ST_ESPERA && !w_jogada_ed && !w_expirou) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end
`else
    assign w_expirou = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= ST_INICIAL;
            r_saidas   <= SAI_NADA;
            r_jogada_q <= 1'b0;
            r_contagem <= '0;
            r_registro <= '0;
        end else begin
            // Tracks in every state so an edge outside ESPERA is consumed, not queued.
            r_jogada_q <= bus.jogada;
            case (r_estado)
                ST_INICIAL: begin
                    if (bus.iniciar) r_estado <= ST_PREPARACAO;
                end
                ST_PREPARACAO: begin
                    r_contagem <= '0;
                    r_registro <= '0;
                    r_estado   <= ST_ESPERA;
                end
                ST_ESPERA: begin
                    if (w_jogada_ed) begin
                        r_estado <= ST_REGISTRA;
                    end else if (w_expirou) begin
                        r_estado <= ST_FIM_TIMEOUT;
                        r_saidas <= SAI_TIMEOUT;
                    end
                end
                ST_REGISTRA: begin
                    r_registro <= bus.chaves;
                    r_estado   <= ST_COMPARA;
                end
                ST_COMPARA: begin
                    if (!w_igual) begin
                        r_estado <= ST_FIM_ERRO;
                        r_saidas <= SAI_ERRO;
                    end else if (r_contagem == ULTIMA) begin
                        r_estado <= ST_FIM_ACERTO;
                        r_saidas <= SAI_ACERTO;
                    end else begin
                        r_estado <= ST_PROXIMO;
                    end
                end
                ST_PROXIMO: begin
                    r_contagem <= r_contagem + ADDR_W'(1);
                    r_estado   <= ST_ESPERA;
                end
                ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
                    if (bus.iniciar) begin
                        r_estado <= ST_PREPARACAO;
                        r_saidas <= SAI_NADA;
                    end
                end
                default: begin
                    r_estado <= ST_INICIAL;
                    r_saidas <= SAI_NADA;
                end
            endcase
        end
    end

    assign bus.pronto      = r_saidas.pronto;
    assign bus.acertou     = r_saidas.acertou;
    assign bus.errou       = r_saidas.errou;
    assign bus.timeout     = r_saidas.timeout;
    assign bus.db_igual    = w_igual;
    assign bus.db_contagem = r_contagem;
    assign bus.db_memoria  = w_memoria;
    assign bus.db_jogada   = r_registro;
    assign bus.db_estado   = r_estado;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param with DATA_W=4, DEPTH=4 (ROM = 1,4,7,A), TIMEOUT_CYCLES=8.
// Timeout checks follow JOGO_SEQUENCIA_TIMEOUT_EN; otherwise the timeout flag must stay 0.
module tb_jogo_sequencia_param;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TC    = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    jogo_sequencia_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    jogo_sequencia_param #(
        .DATA_W         (DW),
        .DEPTH          (DEPTH),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         novo;
        logic [3:0] v;
        logic [3:0] estado;
        logic [1:0] cont;
    } vec_t;

    vec_t tab[6];

    function automatic int ref_rom(input int a);
        return (3 * a + 1) % 16;
    endfunction

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start();
        bus.iniciar = 1'b1;
        tick();
        chk("start_prep", bus.db_estado, 32'h1);
        bus.iniciar = 1'b0;
        tick();
        chk("start_espera", bus.db_estado, 32'h2);
    endtask

    task automatic entry(input logic [3:0] v, output logic [3:0] verd);
        bus.chaves = v;
        bus.jogada = 1'b1;
        tick();
        chk("entry_registra", bus.db_estado, 32'h3);
        tick();
        chk("entry_compara", bus.db_estado, 32'h4);
        chk("entry_db_jogada", bus.db_jogada, v);
        tick();
        verd = bus.db_estado;
        bus.jogada = 1'b0;
        if (verd == 4'h5) begin
            tick();
            chk("entry_volta_espera", bus.db_estado, 32'h2);
        end
    endtask

    task automatic finish_round(input int from_pos);
        logic [3:0] vd;
        for (int p = from_pos; p < DEPTH; p++) begin
            entry(4'(ref_rom(p)), vd);
            chk("finish_round_verd", vd, (p == DEPTH - 1) ? 32'hA : 32'h5);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] verd;
        logic [3:0] v;
        logic [3:0] exp_v;
        int idle;

        tab[0] = '{novo: 1'b1, v: 4'h1, estado: 4'h5, cont: 2'd1};
        tab[1] = '{novo: 1'b0, v: 4'h4, estado: 4'h5, cont: 2'd2};
        tab[2] = '{novo: 1'b0, v: 4'h7, estado: 4'h5, cont: 2'd3};
        tab[3] = '{novo: 1'b0, v: 4'hA, estado: 4'hA, cont: 2'd3};
        tab[4] = '{novo: 1'b1, v: 4'h1, estado: 4'h5, cont: 2'd1};
        tab[5] = '{novo: 1'b0, v: 4'h5, estado: 4'hE, cont: 2'd1};

        bus.iniciar = 1'b0;
        bus.jogada  = 1'b0;
        bus.chaves  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_estado", bus.db_estado, 32'h0);
        chk("rst_cont", bus.db_contagem, 32'h0);
        chk("rst_flags", {bus.pronto, bus.acertou, bus.errou, bus.timeout}, 32'h0);
        chk("rst_memoria", bus.db_memoria, 32'h1);
        chk("rst_db_jogada", bus.db_jogada, 32'h0);
        chk("rst_igual", bus.db_igual, 32'h0);
        reset = 1'b1;
        tick();
        chk("idle_inicial", bus.db_estado, 32'h0);

        // Reset in the middle of a round, with the FSM sitting in COMPARA
        start();
        entry(4'h1, verd);
        chk("mid_first", verd, 32'h5);
        bus.chaves = 4'h4;
        bus.jogada = 1'b1;
        tick();
        tick();
        chk("mid_in_compara", bus.db_estado, 32'h4);
        reset = 1'b0;
        #1;
        chk("mid_async_estado", bus.db_estado, 32'h0);
        tick();
        chk("mid_estado", bus.db_estado, 32'h0);
        chk("mid_cont", bus.db_contagem, 32'h0);
        chk("mid_flags", {bus.pronto, bus.acertou, bus.errou}, 32'h0);
        chk("mid_memoria", bus.db_memoria, 32'h1);
        chk("mid_db_jogada", bus.db_jogada, 32'h0);
        reset = 1'b1;
        bus.jogada = 1'b0;
        tick();

        // Table: full hit, then a miss on the second entry
        for (int i = 0; i < 6; i++) begin
            if (tab[i].novo) start();
            entry(tab[i].v, verd);
            chk("tab_verd", verd, tab[i].estado);
            chk("tab_cont", bus.db_contagem, tab[i].cont);
            if (tab[i].estado == 4'hA) begin
                chk("tab_hit_flags", {bus.pronto, bus.acertou, bus.errou, bus.timeout}, 32'b1100);
                repeat (5) tick();
                chk("tab_hit_hold", bus.db_estado, 32'hA);
                chk("tab_hit_hold_flags", {bus.pronto, bus.acertou}, 32'b11);
            end
            if (tab[i].estado == 4'hE) begin
                chk("tab_miss_flags", {bus.pronto, bus.acertou, bus.errou, bus.timeout}, 32'b1010);
                chk("tab_miss_db_jogada", bus.db_jogada, tab[i].v);
                chk("tab_miss_memoria", bus.db_memoria, ref_rom(int'(tab[i].cont)));
                chk("tab_miss_igual", bus.db_igual, 32'h0);
                repeat (5) tick();
                chk("tab_miss_hold", bus.db_estado, 32'hE);
            end
        end

        // jogada held high: one event only
        start();
        bus.chaves = 4'h1;
        bus.jogada = 1'b1;
        repeat (20) tick();
        chk("hold_cont", bus.db_contagem, 32'h1);
        chk("hold_estado", bus.db_estado, 32'h2);
        bus.chaves = 4'h4;
        tick();
        chk("hold_no_second", bus.db_estado, 32'h2);
        bus.jogada = 1'b0;
        tick();
        entry(4'h4, verd);
        chk("hold_second_rise", verd, 32'h5);
        chk("hold_cont2", bus.db_contagem, 32'h2);
        finish_round(2);

        // Rise during PREPARACAO is dropped; iniciar in ESPERA is ignored
        bus.iniciar = 1'b1;
        tick();
        chk("prep_estado", bus.db_estado, 32'h1);
        bus.iniciar = 1'b0;
        bus.chaves  = 4'h1;
        bus.jogada  = 1'b1;
        tick();
        repeat (2) tick();
        chk("prep_rise_ignored", bus.db_estado, 32'h2);
        chk("prep_rise_cont", bus.db_contagem, 32'h0);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        tick();
        chk("iniciar_in_espera", bus.db_estado, 32'h2);
        bus.jogada = 1'b0;
        tick();
        finish_round(0);

`ifdef JOGO_SEQUENCIA_TIMEOUT_EN
        start();
        repeat (TC - 1) tick();
        chk("to_before", bus.db_estado, 32'h2);
        tick();
        chk("to_estado", bus.db_estado, 32'hF);
        chk("to_flags", {bus.pronto, bus.acertou, bus.errou, bus.timeout}, 32'b1011);
        start();
        repeat (TC - 1) tick();
        bus.chaves = 4'h1;
        bus.jogada = 1'b1;
        tick();
        chk("to_edge_wins", bus.db_estado, 32'h3);
        tick();
        tick();
        chk("to_edge_verd", bus.db_estado, 32'h5);
        bus.jogada = 1'b0;
        tick();
        finish_round(1);
`else
        start();
        repeat (20) tick();
        chk("noto_estado", bus.db_estado, 32'h2);
        chk("noto_timeout", bus.timeout, 32'h0);
        finish_round(0);
`endif

        // Randomised rounds against the sequence model
        for (int r = 0; r < 25; r++) begin
            start();
            for (int p = 0; p < DEPTH; p++) begin
                idle = $urandom_range(0, 3);
                repeat (idle) tick();
                exp_v = 4'(ref_rom(p));
                v = ($urandom_range(0, 9) < 8) ? exp_v : 4'($urandom_range(0, 15));
                entry(v, verd);
                if (v != exp_v) begin
                    chk("rnd_miss", verd, 32'hE);
                    chk("rnd_miss_cont", bus.db_contagem, p);
                    chk("rnd_miss_flags", {bus.pronto, bus.acertou, bus.errou}, 32'b101);
                    break;
                end else if (p == DEPTH - 1) begin
                    chk("rnd_hit", verd, 32'hA);
                    chk("rnd_hit_flags", {bus.pronto, bus.acertou, bus.errou}, 32'b110);
                    chk("rnd_hit_igual", bus.db_igual, 32'h1);
                end else begin
                    chk("rnd_next", verd, 32'h5);
                    chk("rnd_next_cont", bus.db_contagem, p + 1);
                    chk("rnd_next_memoria", bus.db_memoria, ref_rom(p + 1));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
